// File: rtl/mesh_port_arbiter_if.sv
// Input-FIFO side and holding-stage side of one mesh router output-port arbiter.
// The master modport is the arbiter; slave is the FIFOs plus downstream consumer.
interface mesh_port_arbiter_if #(
  parameter int unsigned pckg_sz = 40,
  parameter int unsigned N_IN    = 4
);
  logic [N_IN-1:0]         pndng_in;
  logic [N_IN*pckg_sz-1:0] data_in;
  logic [N_IN-1:0]         pop;
  logic                    out_pndng;
  logic [pckg_sz-1:0]      out_data;
  logic                    out_pop;
  logic [2:0]              grant_idx;

  modport master (
    input  pndng_in, data_in, out_pop,
    output pop, out_pndng, out_data, grant_idx
  );

  modport slave (
    output pndng_in, data_in, out_pop,
    input  pop, out_pndng, out_data, grant_idx
  );
endinterface

// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter sharing one router output direction between N_IN input FIFOs,
// feeding a one-entry holding stage drained by a pop/pending handshake.
module mesh_port_arbiter #(
  parameter int unsigned pckg_sz  = 40,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned ID_ROW   = 0,
  parameter int unsigned ID_COL   = 0,
  parameter int unsigned PORT_DIR = 0
) (
  input logic                 clk,
  input logic                 reset,
  mesh_port_arbiter_if.master bus
);
  localparam int unsigned PTR_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [3:0]  MY_ROW = 4'(ID_ROW);
  localparam logic [3:0]  MY_COL = 4'(ID_COL);
  localparam logic [2:0]  DIR    = 3'(PORT_DIR);
  localparam logic [2:0]  D_N    = 3'd0;
  localparam logic [2:0]  D_S    = 3'd1;
  localparam logic [2:0]  D_E    = 3'd2;
  localparam logic [2:0]  D_W    = 3'd3;
  localparam logic [2:0]  D_L    = 3'd4;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [pckg_sz-1:0] out_data_q, out_data_d;
  logic [2:0]         grant_idx_q, grant_idx_d;
  logic [N_IN-1:0]    req;
  logic [N_IN-1:0]    pop_c;
  logic [N_IN-1:0]    unused_jump;
  logic [PTR_W-1:0]   winner;
  logic [pckg_sz-9:0] win_tail;
  logic               found;
  logic               stage_free;
  logic               grant;
  int unsigned        idx;
  logic [pckg_sz-1:0] in_word [N_IN];

  // Unsigned 4-bit compare via borrow, returns {a<b, a>b}.
  function automatic logic [1:0] cmp4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] d;
    d = {1'b0, a} - {1'b0, b};
    return {d[4], !d[4] && (|d[3:0])};
  endfunction

  function automatic logic [2:0] route(input logic [3:0] trow, input logic [3:0] tcol,
                                       input logic mode);
    logic [1:0] rc, cc;
    logic [2:0] dir;
    rc  = cmp4(trow, MY_ROW);
    cc  = cmp4(tcol, MY_COL);
    dir = D_L;
    if (mode) begin
      if (rc[1])      dir = D_N;
      else if (rc[0]) dir = D_S;
      else if (cc[1]) dir = D_W;
      else if (cc[0]) dir = D_E;
    end else begin
      if (cc[1])      dir = D_W;
      else if (cc[0]) dir = D_E;
      else if (rc[1]) dir = D_N;
      else if (rc[0]) dir = D_S;
    end
    return dir;
  endfunction

  // Per-input request: FIFO not empty and head packet routed to this port.
  for (genvar g = 0; g < N_IN; g++) begin : g_in
    assign in_word[g]     = bus.data_in[g*pckg_sz +: pckg_sz];
    assign req[g]         = bus.pndng_in[g] &&
                            (route(in_word[g][pckg_sz-9 -: 4], in_word[g][pckg_sz-13 -: 4],
                                   in_word[g][pckg_sz-17]) == DIR);
    // incoming nxt_jump is overwritten with this router's id on grant
    assign unused_jump[g] = ^in_word[g][pckg_sz-1 -: 8];
  end

  // First requester at or after rr_ptr, wrapping modulo N_IN.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = (32'(rr_ptr_q) + k) % N_IN;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
    win_tail = in_word[winner][pckg_sz-9:0];
  end

  // Holding-stage FSM, pop generation and next-state datapath.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    grant_idx_d = grant_idx_q;
    pop_c       = '0;
    stage_free  = (state_q == EMPTY) || bus.out_pop;
    grant       = stage_free && found && !reset;

    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (bus.out_pop && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (grant) begin
      pop_c[winner] = 1'b1;
      out_data_d    = {MY_ROW, MY_COL, win_tail};
      rr_ptr_d      = (32'(winner) == N_IN - 1) ? '0 : PTR_W'(winner + 1'b1);
      grant_idx_d   = 3'(winner);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.out_pndng = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.grant_idx = grant_idx_q;
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter: FIFO model on an E port with a scoreboard
// on delivered packets, plus LOCAL and N instances sharing a second input set.
module tb_mesh_port_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mesh_port_arbiter_if #(.pckg_sz(40), .N_IN(4)) bus_e ();
  mesh_port_arbiter_if #(.pckg_sz(40), .N_IN(4)) bus_l ();
  mesh_port_arbiter_if #(.pckg_sz(40), .N_IN(4)) bus_n ();

  mesh_port_arbiter #(.pckg_sz(40), .N_IN(4), .ID_ROW(1), .ID_COL(1), .PORT_DIR(2))
    dut_e (.clk(clk), .reset(reset), .bus(bus_e));
  mesh_port_arbiter #(.pckg_sz(40), .N_IN(4), .ID_ROW(1), .ID_COL(1), .PORT_DIR(4))
    dut_l (.clk(clk), .reset(reset), .bus(bus_l));
  mesh_port_arbiter #(.pckg_sz(40), .N_IN(4), .ID_ROW(1), .ID_COL(1), .PORT_DIR(0))
    dut_n (.clk(clk), .reset(reset), .bus(bus_n));

  int n_checks = 0;
  int n_err    = 0;

  logic [39:0] exp_q [$];

  // Input FIFO model for the E instance, popped by the DUT's pop pulses.
  logic [39:0] fifo_mem [4][16];
  int unsigned wr [4];
  int unsigned rd [4];
  logic        flush   = 1'b0;
  logic        e_opop  = 1'b0;

  always_comb begin
    bus_e.pndng_in = '0;
    bus_e.data_in  = '0;
    for (int i = 0; i < 4; i++) begin
      bus_e.pndng_in[i]        = (rd[i] != wr[i]);
      bus_e.data_in[i*40 +: 40] = fifo_mem[i][rd[i] % 16];
    end
  end
  assign bus_e.out_pop = e_opop;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush)              rd[i] <= wr[i];
      else if (bus_e.pop[i])  rd[i] <= rd[i] + 1;
    end
  end

  logic [3:0]   l_pndng = '0;
  logic [159:0] l_data  = '0;
  assign bus_l.pndng_in = l_pndng;
  assign bus_l.data_in  = l_data;
  assign bus_l.out_pop  = 1'b1;
  assign bus_n.pndng_in = l_pndng;
  assign bus_n.data_in  = l_data;
  assign bus_n.out_pop  = 1'b1;

  function automatic logic [39:0] mk(input logic mode, input logic [3:0] trow,
                                     input logic [3:0] tcol, input logic [22:0] pay);
    return {8'hA5, trow, tcol, mode, pay};
  endfunction

  function automatic logic [39:0] exp_of(input logic [39:0] p);
    return {8'h11, p[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input int i, input logic [39:0] p, input bit expect_out);
    fifo_mem[i][wr[i] % 16] = p;
    wr[i] = wr[i] + 1;
    if (expect_out) exp_q.push_back(exp_of(p));
  endtask

  // Scoreboard monitor: compares every packet the E port hands downstream.
  always @(negedge clk) begin
    if (!reset && bus_e.out_pndng && bus_e.out_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %0h, expected no packet", bus_e.out_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if (bus_e.out_data !== e) begin
          n_err++;
          $display("FAIL sb_data: got %0h, expected %0h (t=%0t)", bus_e.out_data, e, $time);
        end
      end
    end
    n_checks++;
    if ($countones(bus_e.pop) > 1) begin
      n_err++;
      $display("FAIL pop_onehot: got %b, expected at most one bit", bus_e.pop);
    end
  end

  logic [39:0] a0, a1, b0, c0, d0, e0, pa, pb, pc;

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    sample();
    chk("rst_pndng", 64'(bus_e.out_pndng), 64'd0);
    chk("rst_data",  64'(bus_e.out_data),  64'd0);
    chk("rst_gidx",  64'(bus_e.grant_idx), 64'd0);
    chk("rst_pop",   64'(bus_e.pop),       64'd0);

    // 1: E-routed packet, one-cycle pop then out_pndng with stamped nxt_jump
    tick();
    push(0, mk(1'b1, 4'd1, 4'd3, 23'h12345), 1'b1);
    sample();
    chk("t1_pop", 64'(bus_e.pop), 64'b0001);
    tick(); sample();
    chk("t1_pndng", 64'(bus_e.out_pndng), 64'd1);
    chk("t1_jump",  64'(bus_e.out_data[39:32]), 64'h11);
    chk("t1_pop_off", 64'(bus_e.pop), 64'd0);
    tick(); e_opop = 1'b1; sample();
    tick(); e_opop = 1'b0; sample();
    chk("t1_drained", 64'(bus_e.out_pndng), 64'd0);

    // 2: N-routed packet never taken by the E port
    tick();
    push(0, mk(1'b1, 4'd0, 4'd3, 23'h00abc), 1'b0);
    for (int c = 0; c < 20; c++) begin
      sample();
      chk("t2_pop",   64'(bus_e.pop),       64'd0);
      chk("t2_pndng", 64'(bus_e.out_pndng), 64'd0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // 3: four inputs competing with out_pop tied high
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    e_opop = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        push(i, mk(1'b0, 4'd1, 4'd5 + 4'(i), 23'(r * 16 + i)), 1'b1);
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("t3_pop", 64'(bus_e.pop), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("t3_gidx", 64'(bus_e.grant_idx), 64'((k - 1) % 4));
      tick();
    end
    sample();
    chk("t3_pop_end", 64'(bus_e.pop), 64'd0);
    tick(); sample();
    chk("t3_drained", 64'(bus_e.out_pndng), 64'd0);

    // 4: backpressure freezes the stage, release reloads from rr_ptr=2
    tick();
    e_opop = 1'b0;
    a0 = mk(1'b1, 4'd1, 4'd2, 23'h0000a1);
    a1 = mk(1'b1, 4'd1, 4'd9, 23'h0000a2);
    b0 = mk(1'b0, 4'd7, 4'd4, 23'h0000b0);
    push(1, a0, 1'b1);
    push(2, b0, 1'b1);
    push(1, a1, 1'b1);
    sample();
    chk("t4_pop_first", 64'(bus_e.pop), 64'b0010);
    for (int c = 0; c < 5; c++) begin
      tick(); sample();
      chk("t4_hold_pop",  64'(bus_e.pop),      64'd0);
      chk("t4_hold_data", 64'(bus_e.out_data), 64'(exp_of(a0)));
    end
    tick(); e_opop = 1'b1; sample();
    chk("t4_reload_pop", 64'(bus_e.pop), 64'b0100);
    tick(); sample();
    chk("t4_next_pop", 64'(bus_e.pop), 64'b0010);
    tick(); sample();
    chk("t4_last_pop", 64'(bus_e.pop), 64'd0);
    tick(); sample();
    chk("t4_drained", 64'(bus_e.out_pndng), 64'd0);

    // 5: reset while holding discards the packet and restarts at input 0
    tick();
    e_opop = 1'b0;
    c0 = mk(1'b1, 4'd1, 4'd6, 23'h0000c0);
    d0 = mk(1'b1, 4'd1, 4'd7, 23'h0000d0);
    e0 = mk(1'b0, 4'd3, 4'd8, 23'h0000e0);
    push(1, c0, 1'b1);
    sample();
    chk("t5_pop_c0", 64'(bus_e.pop), 64'b0010);
    tick();
    push(0, d0, 1'b0);
    push(2, e0, 1'b0);
    sample();
    chk("t5_full_pop", 64'(bus_e.pop), 64'd0);
    tick();
    reset  = 1'b1;
    e_opop = 1'b1;
    exp_q.delete();
    sample();
    chk("t5_rst_pop", 64'(bus_e.pop), 64'd0);
    tick();
    reset = 1'b0;
    exp_q.push_back(exp_of(d0));
    exp_q.push_back(exp_of(e0));
    sample();
    chk("t5_pndng", 64'(bus_e.out_pndng), 64'd0);
    chk("t5_data",  64'(bus_e.out_data),  64'd0);
    chk("t5_gidx",  64'(bus_e.grant_idx), 64'd0);
    chk("t5_pop0",  64'(bus_e.pop),       64'b0001);
    tick(); sample();
    chk("t5_pop2", 64'(bus_e.pop), 64'b0100);
    tick(); sample();
    chk("t5_pop_end", 64'(bus_e.pop), 64'd0);
    tick(); sample();
    chk("t5_drained", 64'(bus_e.out_pndng), 64'd0);

    // 6: packets addressed to this router go LOCAL under both modes
    pa = mk(1'b0, 4'd1, 4'd1, 23'h0000aa);
    pb = mk(1'b1, 4'd1, 4'd1, 23'h0000bb);
    pc = mk(1'b1, 4'd0, 4'd1, 23'h0000cc);
    tick();
    l_data[0 +: 40]  = pa;
    l_data[80 +: 40] = pb;
    l_pndng = 4'b0101;
    sample();
    chk("t6_l_pop_a", 64'(bus_l.pop), 64'b0001);
    chk("t6_n_pop_a", 64'(bus_n.pop), 64'd0);
    tick();
    l_pndng = 4'b0100;
    sample();
    chk("t6_l_pndng", 64'(bus_l.out_pndng), 64'd1);
    chk("t6_l_data_a", 64'(bus_l.out_data), 64'(exp_of(pa)));
    chk("t6_l_pop_b", 64'(bus_l.pop), 64'b0100);
    chk("t6_n_pop_b", 64'(bus_n.pop), 64'd0);
    tick();
    l_pndng = 4'b0000;
    sample();
    chk("t6_l_data_b", 64'(bus_l.out_data), 64'(exp_of(pb)));
    chk("t6_l_pop_idle", 64'(bus_l.pop), 64'd0);
    chk("t6_n_pndng", 64'(bus_n.out_pndng), 64'd0);
    tick();
    l_data[40 +: 40] = pc;
    l_pndng = 4'b0010;
    sample();
    chk("t6_n_pop_c", 64'(bus_n.pop), 64'b0010);
    chk("t6_l_pop_c", 64'(bus_l.pop), 64'd0);
    tick();
    l_pndng = 4'b0000;
    sample();
    chk("t6_n_pndng_c", 64'(bus_n.out_pndng), 64'd1);
    chk("t6_n_data_c",  64'(bus_n.out_data),  64'(exp_of(pc)));

    tick(); sample();
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mesh_port_arbiter.md
Name: mesh_port_arbiter

Overview:
- Round-robin output-port arbiter for one router of the mesh_gnrtr array.
- Shares one output direction (N/S/E/W/local) between N_IN input FIFOs. Only packets whose routed direction equals this port are considered.
- Pops the winning FIFO and loads the packet into a one-entry output holding stage. The downstream FIFO or terminal drains that stage with a pop/pending handshake.
- Instantiated five times per router, once per PORT_DIR.

Parameters:
- pckg_sz, 40: packet width in bits.
- N_IN, 4: number of competing input FIFOs (2..8).
- ID_ROW, 0: row of the owning router (4-bit).
- ID_COL, 0: column of the owning router (4-bit).
- PORT_DIR, 0: direction served by this instance: 0=N, 1=S, 2=E, 3=W, 4=LOCAL.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- pndng_in  in  N_IN  per-input FIFO not-empty.
- data_in  in  N_IN*pckg_sz  per-input FIFO head word, first-word-fall-through; input i occupies bits [i*pckg_sz +: pckg_sz].
- pop  out  N_IN  one-cycle pop pulse to input FIFO i.
- out_pndng  out  1  holding stage holds a valid packet.
- out_data  out  pckg_sz  packet in the holding stage.
- out_pop  in  1  downstream consumes out_data this cycle. Ignored when out_pndng=0.
- grant_idx  out  3  index of the last granted input (debug/coverage).

Behaviour:
- Packet fields:
  - [pckg_sz-1:pckg_sz-8] nxt_jump
  - [pckg_sz-9:pckg_sz-12] target row (trow)
  - [pckg_sz-13:pckg_sz-16] target column (tcol)
  - [pckg_sz-17] mode
  - remaining bits: payload
- Route function (combinational, per input):
  - mode=1, row first: trow<ID_ROW → N; trow>ID_ROW → S; otherwise tcol<ID_COL → W; tcol>ID_COL → E; otherwise LOCAL.
  - mode=0, column first: compare columns first (W/E), then rows (N/S), otherwise LOCAL.
  - All comparisons are unsigned 4-bit.
- req[i] = pndng_in[i] AND route(data_in[i]) == PORT_DIR.
- Stage free when out_pndng=0, or when out_pndng=1 and out_pop=1 (back-to-back, 1 packet/cycle max).
- Grant cycle, when the stage is free and |req:
  - Winner = first req at or after rr_ptr, wrapping modulo N_IN.
  - pop[winner]=1 combinationally in that cycle. At most one pop bit is high.
  - At the clock edge: out_data ← data_in[winner] with nxt_jump replaced by {ID_ROW,ID_COL}; out_pndng ← 1; rr_ptr ← winner+1 mod N_IN; grant_idx ← winner.
  - Latency: req at cycle t → out_pndng at t+1.
- No grant when req=0 or stage not free: pop=0. If out_pop=1 and no req, out_pndng ← 0 at the edge.
- Hold: out_data is stable while out_pndng=1 and out_pop=0.
- FSM (2 states):
  - EMPTY: grant → FULL.
  - FULL: out_pop with no req → EMPTY. out_pop with req → FULL (reload). No out_pop → FULL.
- Fairness: each requesting input is granted within N_IN grants. rr_ptr does not move on idle cycles.
- Inputs routed to other directions are never popped by this instance.
- Reset (any cycle, including mid-hold):
  - Next edge: out_pndng=0, out_data=0, pop=0, rr_ptr=0, grant_idx=0, state EMPTY. A held packet is discarded.
  - pop is forced 0 while reset=1.

Test Plan:
1. ID_ROW=1, ID_COL=1, PORT_DIR=2, mode=1. Input 0 holds trow=1, tcol=3 → pop[0] pulses 1 cycle; next cycle out_pndng=1 and out_data[39:32]=8'h11.
2. Same config, trow=0, tcol=3, mode=1 → routes N. No pop, out_pndng stays 0 for 20 cycles.
3. All 4 inputs request E continuously, out_pop tied 1 → grants 0,1,2,3,0,… one per cycle, each pop a single pulse.
4. out_pop held 0 for 5 cycles with inputs 1 and 2 requesting → out_data frozen, no pops. Raising out_pop gives same-cycle pop[2] (rr_ptr=2) and a reload.
5. Reset asserted while out_pndng=1 → next edge out_pndng=0, out_data=0. First grant after release goes to input 0.
6. PORT_DIR=4, trow=ID_ROW, tcol=ID_COL under mode 0 and mode 1 → both delivered LOCAL. Same packets on a PORT_DIR=0 instance → ignored.
